dt_stat_scan: RTL and testbench

Post-processing stage that sits directly downstream of the distance-transform engine. After the transform has filled the 128x128 result RAM, this block reads every distance byte and reports the maximum distance, the lowest address where it occurs, the foreground pixel count and the count of pixels at or above a threshold. It shares the result-RAM read port with the transform engine, which is idle once the transform has signalled done.

---
 rtl/dt_stat_scan.sv | 114 +++++++++++
 tb/tb_dt_stat_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dt_stat_scan.sv
// Scans the distance-transform result RAM; reports max distance/address, foreground and threshold counts.
// Latency: one read per cycle, done two edges after the last address is driven. No backpressure.
// Build option BORDER_SKIP_EN: read interior pixels only, skipping the one-pixel border.
module dt_stat_scan #(
  parameter int          IMG_W  = 128,
  parameter int          ADDR_W = 14,
  parameter logic [7:0]  THRESH = 8'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              busy,
  output logic              done,
  output logic [7:0]        max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W:0]   fg_cnt,
  output logic [ADDR_W:0]   thr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

`ifdef BORDER_SKIP_EN
  localparam int XW = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'((IMG_W - 1) * IMG_W - 2);
`else
  localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_W - 1);
`endif
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic              start_acc;
  logic [ADDR_W-1:0] addr_step;
  logic              samp_vld;
  logic [ADDR_W-1:0] samp_addr;
  logic [7:0]        samp_dat;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    res_rd    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done      = (state == S_DONE);
        start_acc = start;
        if (start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        res_rd = 1'b1;
        busy   = 1'b1;
        if (res_addr == LAST_ADDR) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Jump over the right border column and the left border column of the next row.
  always_comb begin
    addr_step = ADDR_W'(1);
`ifdef BORDER_SKIP_EN
    if (res_addr[XW-1:0] == XW'(IMG_W - 2)) addr_step = ADDR_W'(3);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_addr  <= '0;
      samp_vld  <= 1'b0;
      samp_addr <= '0;
      samp_dat  <= '0;
      max_val   <= '0;
      max_addr  <= '0;
      fg_cnt    <= '0;
      thr_cnt   <= '0;
    end else if (start_acc) begin
      res_addr  <= FIRST_ADDR;
      samp_vld  <= 1'b0;
      max_val   <= '0;
      max_addr  <= '0;
      fg_cnt    <= '0;
      thr_cnt   <= '0;
    end else begin
      if (state == S_SCAN && res_addr != LAST_ADDR) res_addr <= res_addr + addr_step;
      samp_vld  <= (state == S_SCAN);
      samp_addr <= res_addr;
      samp_dat  <= res_di;
      // Strict compare keeps the lowest address on ties.
      if (samp_vld) begin
        if (samp_dat > max_val) begin
          max_val  <= samp_dat;
          max_addr <= samp_addr;
        end
        if (samp_dat != 8'd0)   fg_cnt  <= fg_cnt + CNT_ONE;
        if (samp_dat >= THRESH) thr_cnt <= thr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dt_stat_scan.sv
// Directed bench for dt_stat_scan with a RAM-level reference model.
module tb_dt_stat_scan;
  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam logic [7:0] THR = 8'd4;
`ifdef BORDER_SKIP_EN
  localparam int NREAD = (IMG_W - 2) * (IMG_W - 2);
  localparam int FIRST = IMG_W + 1;
`else
  localparam int NREAD = NPIX;
  localparam int FIRST = 0;
`endif
  localparam int LAT = NREAD + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_di;
  logic              busy;
  logic              done;
  logic [7:0]        max_val;
  logic [ADDR_W-1:0] max_addr;
  logic [ADDR_W:0]   fg_cnt;
  logic [ADDR_W:0]   thr_cnt;

  logic [7:0] mem [0:NPIX-1];
  assign res_di = mem[res_addr];

  dt_stat_scan #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .THRESH(THR)) dut (
    .clk(clk), .reset(reset), .start(start), .res_rd(res_rd), .res_addr(res_addr),
    .res_di(res_di), .busy(busy), .done(done), .max_val(max_val), .max_addr(max_addr),
    .fg_cnt(fg_cnt), .thr_cnt(thr_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_max, exp_addr, exp_fg, exp_thr;
  bit exp_ok = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // i-th pixel visited in raster order over the readable region.
  function automatic int nth_addr(input int i);
`ifdef BORDER_SKIP_EN
    return (1 + i / (IMG_W - 2)) * IMG_W + 1 + i % (IMG_W - 2);
`else
    return i;
`endif
  endfunction

  task automatic model();
    int a;
    exp_max = 0; exp_addr = 0; exp_fg = 0; exp_thr = 0;
    for (int i = 0; i < NREAD; i++) begin
      a = nth_addr(i);
      if (int'(mem[a]) > exp_max) begin exp_max = mem[a]; exp_addr = a; end
      if (mem[a] != 0)   exp_fg++;
      if (mem[a] >= THR) exp_thr++;
    end
  endtask

  // Address trace and held results, checked every cycle they are meaningful.
  int idx = 0;
  always @(negedge clk) begin
    if (res_rd) begin
      chk("addr_seq", res_addr, nth_addr(idx));
`ifdef BORDER_SKIP_EN
      chk("border_read", (res_addr % IMG_W == 0) || (res_addr % IMG_W == IMG_W-1) ||
                         (res_addr / IMG_W == 0) || (res_addr / IMG_W == IMG_W-1), 0);
`endif
      idx++;
    end else begin
      idx = 0;
    end
    if (done && exp_ok) begin
      chk("max_val", max_val, exp_max);
      chk("max_addr", max_addr, exp_addr);
      chk("fg_cnt", fg_cnt, exp_fg);
      chk("thr_cnt", thr_cnt, exp_thr);
      chk("busy_in_done", busy, 0);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_res_rd"}, res_rd, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_max_val"}, max_val, 0);
    chk({tag, "_max_addr"}, max_addr, 0);
    chk({tag, "_fg_cnt"}, fg_cnt, 0);
    chk({tag, "_thr_cnt"}, thr_cnt, 0);
  endtask

  // Start at edge E, optionally re-pulse start mid-scan, then time the done edge.
  task automatic run_scan(input int mid_start);
    int k;
    exp_ok = 0;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("after_start_done", done, 0);
    chk("after_start_busy", busy, 1);
    chk("after_start_res_rd", res_rd, 1);
    chk("after_start_addr", res_addr, FIRST);
    chk("after_start_fg_clr", fg_cnt, 0);
    chk("after_start_max_clr", max_val, 0);
    exp_ok = 1;
    k = 0;
    while (!done && k < LAT + 50) begin
      @(negedge clk);
      k++;
      start = (mid_start > 0 && k == mid_start);
    end
    start = 1'b0;
    chk("done_latency", k, LAT);
  endtask

  task automatic lit(input int mv, input int ma, input int fg, input int th);
    chk("lit_max_val", max_val, mv);
    chk("lit_max_addr", max_addr, ma);
    chk("lit_fg_cnt", fg_cnt, fg);
    chk("lit_thr_cnt", thr_cnt, th);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle");

`ifdef BORDER_SKIP_EN
    chk("model_first", nth_addr(0), 129);
    chk("model_after_254", nth_addr(126), 257);
    chk("model_after_382", nth_addr(252), 385);
    chk("model_last", nth_addr(NREAD-1), 16254);
`else
    chk("model_first", nth_addr(0), 0);
    chk("model_last", nth_addr(NREAD-1), 16383);
`endif

    // All-zero image.
    run_scan(0);
    lit(0, 0, 0, 0);

    // Single value in the middle of the image.
    mem[8256] = 8'd5;
    run_scan(0);
    lit(5, 8256, 1, 1);

    // Tie on max keeps the lower address; a start mid-scan is ignored.
    mem[8256] = 8'd0;
    mem[200] = 8'd3; mem[300] = 8'd3; mem[400] = 8'd2;
    run_scan(3000);
    lit(3, 200, 3, 0);

    // Saturated image: reset mid-scan, then a clean full scan.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
    exp_ok = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (res_addr < 5000 && k < 6000) begin @(negedge clk); k++; end
    chk("reach_5000", (res_addr >= 5000), 1);
    chk("partial_accum", (fg_cnt != 0), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_zero("mid_reset");
    @(negedge clk);
    chk("post_reset_res_rd", res_rd, 0);
    run_scan(0);
`ifdef BORDER_SKIP_EN
    lit(255, 129, 15876, 15876);
`else
    lit(255, 0, 16384, 16384);
`endif

    exp_ok = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
